// File: rtl/alu_pkg.sv
// Shared ALU definitions: function-code encoding used by the ALU and its request controller.
package alu_pkg;

  localparam int unsigned FUNC_W = 3;

  typedef enum logic [FUNC_W-1:0] {
    FUNC_ADD = 3'b000,
    FUNC_SUB = 3'b001,
    FUNC_NOT = 3'b010,
    FUNC_AND = 3'b011,
    FUNC_OR  = 3'b100,
    FUNC_XOR = 3'b101,
    FUNC_SLT = 3'b110,
    FUNC_EQ  = 3'b111
  } alu_func_e;

endpackage

// File: rtl/alu.sv
// Combinational ALU.
//   func     : operation select (alu_pkg::alu_func_e)
//   a, b     : operands, data_len bits
//   result_c : combinational result; compares return 1/0 zero-extended,
//              add/sub wrap modulo 2^data_len
module alu
  import alu_pkg::*;
#(
  parameter int unsigned data_len = 4
) (
  input  alu_func_e           func,
  input  logic [data_len-1:0] a,
  input  logic [data_len-1:0] b,
  output logic [data_len-1:0] result_c
);

  always_comb begin
    result_c = '0;
    case (func)
      FUNC_ADD: result_c = a + b;
      FUNC_SUB: result_c = a - b;
      FUNC_NOT: result_c = ~a;
      FUNC_AND: result_c = a & b;
      FUNC_OR:  result_c = a | b;
      FUNC_XOR: result_c = a ^ b;
      FUNC_SLT: result_c = data_len'($signed(a) < $signed(b));
      FUNC_EQ:  result_c = data_len'(a == b);
      default:  result_c = '0;
    endcase
  end

endmodule

// File: rtl/alu_req_ctrl.sv
// Request/response wrapper around the ALU with an accumulator and a
// completed-operation counter. One command per three cycles:
// IDLE (accept) -> EXEC (compute) -> RESP (hold until consumed).
//   clk, rst              : clock, synchronous active-high reset
//   cmd_valid/cmd_ready   : command handshake (ready only in IDLE)
//   cmd_func, cmd_a, cmd_b: operation and operands
//   cmd_acc               : use accumulator in place of cmd_a
//   acc_clr               : clear accumulator (any state, beats capture)
//   rsp_valid/rsp_ready   : response handshake
//   rsp_result, rsp_zero  : registered result and its all-zero flag
//   acc_value, op_count   : accumulator, count of consumed responses
module alu_req_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned data_len = 4,
  parameter int unsigned cnt_len  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [2:0]          cmd_func,
  input  logic [data_len-1:0] cmd_a,
  input  logic [data_len-1:0] cmd_b,
  input  logic                cmd_acc,
  input  logic                acc_clr,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [data_len-1:0] rsp_result,
  output logic                rsp_zero,
  output logic [data_len-1:0] acc_value,
  output logic [cnt_len-1:0]  op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_e;

  state_e              state_q, state_d;
  logic                load_cmd, capture, complete;
  alu_func_e           func_q;
  logic [data_len-1:0] a_q, b_q;
  logic [data_len-1:0] alu_result;

  // Handshake flags decode directly from the state flop.
  assign cmd_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);

  alu #(.data_len(data_len)) u_alu (
    .func     (func_q),
    .a        (a_q),
    .b        (b_q),
    .result_c (alu_result)
  );

  // Next-state and datapath enables.
  always_comb begin
    state_d  = state_q;
    load_cmd = 1'b0;
    capture  = 1'b0;
    complete = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          load_cmd = 1'b1;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        capture = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          complete = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      func_q     <= FUNC_ADD;
      a_q        <= '0;
      b_q        <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b1;
      acc_value  <= '0;
      op_count   <= '0;
    end else begin
      state_q <= state_d;
      if (load_cmd) begin
        func_q <= alu_func_e'(cmd_func);
        a_q    <= cmd_acc ? acc_value : cmd_a;
        b_q    <= cmd_b;
      end
      if (capture) begin
        rsp_result <= alu_result;
        rsp_zero   <= (alu_result == '0);
      end
      if (acc_clr) begin
        acc_value <= '0;
      end else if (capture) begin
        acc_value <= alu_result;
      end
      if (complete) begin
        op_count <= op_count + cnt_len'(1);
      end
    end
  end

endmodule
